// File: rtl/hicore_lsu_if.sv
// Bus bundle around the LSU: AGU request, data-memory port and writeback result.
// The slave modport is the LSU view; master is the surrounding pipeline/memory.
interface hicore_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int INFO_W = 57
);
    logic              i_agu2lsu_valid;
    logic              o_agu2lsu_ready;
    logic              i_agu2lsu_cancel;
    logic              i_agu2lsu_read;
    logic              i_agu2lsu_unsigned;
    logic              i_agu2lsu_word_access;
    logic              i_agu2lsu_short_access;
    logic              i_agu2lsu_byte_access;
    logic [ADDR_W-1:0] i_agu2lsu_addr;
    logic [DATA_W-1:0] i_agu2lsu_wdata;
    logic [3:0]        i_agu2lsu_wmask;
    logic [INFO_W-1:0] i_agu2lsu_info;

    logic              o_lsu2mem_valid;
    logic              i_lsu2mem_ready;
    logic              o_lsu2mem_read;
    logic [ADDR_W-1:0] o_lsu2mem_addr;
    logic [DATA_W-1:0] o_lsu2mem_wdata;
    logic [3:0]        o_lsu2mem_wmask;

    logic              i_mem2lsu_valid;
    logic [DATA_W-1:0] i_mem2lsu_rdata;
    logic              i_mem2lsu_err;

    logic              o_lsu2wb_valid;
    logic              i_lsu2wb_ready;
    logic [DATA_W-1:0] o_lsu2wb_data;
    logic [INFO_W-1:0] o_lsu2wb_info;

    modport slave (
        input  i_agu2lsu_valid, i_agu2lsu_cancel, i_agu2lsu_read,
        input  i_agu2lsu_unsigned, i_agu2lsu_word_access,
        input  i_agu2lsu_short_access, i_agu2lsu_byte_access,
        input  i_agu2lsu_addr, i_agu2lsu_wdata, i_agu2lsu_wmask,
        input  i_agu2lsu_info,
        output o_agu2lsu_ready,
        output o_lsu2mem_valid, o_lsu2mem_read, o_lsu2mem_addr,
        output o_lsu2mem_wdata, o_lsu2mem_wmask,
        input  i_lsu2mem_ready,
        input  i_mem2lsu_valid, i_mem2lsu_rdata, i_mem2lsu_err,
        output o_lsu2wb_valid, o_lsu2wb_data, o_lsu2wb_info,
        input  i_lsu2wb_ready
    );

    modport master (
        output i_agu2lsu_valid, i_agu2lsu_cancel, i_agu2lsu_read,
        output i_agu2lsu_unsigned, i_agu2lsu_word_access,
        output i_agu2lsu_short_access, i_agu2lsu_byte_access,
        output i_agu2lsu_addr, i_agu2lsu_wdata, i_agu2lsu_wmask,
        output i_agu2lsu_info,
        input  o_agu2lsu_ready,
        input  o_lsu2mem_valid, o_lsu2mem_read, o_lsu2mem_addr,
        input  o_lsu2mem_wdata, o_lsu2mem_wmask,
        output i_lsu2mem_ready,
        output i_mem2lsu_valid, i_mem2lsu_rdata, i_mem2lsu_err,
        input  o_lsu2wb_valid, o_lsu2wb_data, o_lsu2wb_info,
        output i_lsu2wb_ready
    );
endinterface

// File: rtl/hicore_lsu.sv
// LSU front end: one outstanding data-memory access, load formatting,
// exception bypass and flush/drain handling toward writeback.
module hicore_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IRQ_W  = 4,
    parameter int ROB_W  = 5,
    parameter int INFO_W = 16 + 32 + IRQ_W + ROB_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    hicore_lsu_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMD, RSP, WB, DRAIN} state_t;

    state_t            state, state_nx;
    logic              req_read;
    logic              req_unsigned;
    logic [2:0]        req_sz;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_wmask;
    logic [INFO_W-1:0] req_info;
    logic [DATA_W-1:0] wb_data;
    logic [INFO_W-1:0] wb_info;

    logic              accept, take, has_excp, mem_hs, rsp, wb_hs;
    logic [DATA_W-1:0] byte_sh, half_sh, load_data;
    logic              bsign, hsign;
    logic [15:0]       err_excp;

    assign bus.o_agu2lsu_ready = (state == IDLE) & ~flush;
    assign bus.o_lsu2mem_valid = (state == CMD);
    assign bus.o_lsu2wb_valid  = (state == WB) & ~flush;

    assign accept   = bus.i_agu2lsu_valid & bus.o_agu2lsu_ready;
    assign take     = accept & ~bus.i_agu2lsu_cancel;
    assign has_excp = |bus.i_agu2lsu_info[15:0];
    assign mem_hs   = bus.o_lsu2mem_valid & bus.i_lsu2mem_ready;
    assign rsp      = bus.i_mem2lsu_valid;
    assign wb_hs    = bus.o_lsu2wb_valid & bus.i_lsu2wb_ready;

    assign bus.o_lsu2mem_read  = req_read;
    assign bus.o_lsu2mem_addr  = {req_addr[ADDR_W-1:2], 2'b00};
    assign bus.o_lsu2mem_wdata = req_wdata;
    assign bus.o_lsu2mem_wmask = req_wmask;
    assign bus.o_lsu2wb_data   = wb_data;
    assign bus.o_lsu2wb_info   = wb_info;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (take) state_nx = has_excp ? WB : CMD;
            CMD: begin
                if (flush)       state_nx = mem_hs ? DRAIN : IDLE;
                else if (mem_hs) state_nx = RSP;
            end
            RSP: begin
                if (flush)    state_nx = rsp ? IDLE : DRAIN;
                else if (rsp) state_nx = WB;
            end
            WB:    if (flush | wb_hs) state_nx = IDLE;
            DRAIN: if (rsp) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign byte_sh  = bus.i_mem2lsu_rdata >> {req_addr[1:0], 3'b000};
    assign half_sh  = bus.i_mem2lsu_rdata >> {req_addr[1], 4'b0000};
    assign bsign    = byte_sh[7] & ~req_unsigned;
    assign hsign    = half_sh[15] & ~req_unsigned;
    assign err_excp = req_read ? 16'h0020 : 16'h0080;

    always_comb begin
        load_data = bus.i_mem2lsu_rdata;
        unique case (1'b1)
            req_sz[0]: load_data = {{(DATA_W-8){bsign}}, byte_sh[7:0]};
            req_sz[1]: load_data = {{(DATA_W-16){hsign}}, half_sh[15:0]};
            req_sz[2]: load_data = bus.i_mem2lsu_rdata;
            default:   load_data = bus.i_mem2lsu_rdata;
        endcase
    end

    // Result regs load either from an excepting request or a live response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_read     <= 1'b0;
            req_unsigned <= 1'b0;
            req_sz       <= '0;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_wmask    <= '0;
            req_info     <= '0;
            wb_data      <= '0;
            wb_info      <= '0;
        end else begin
            if (take) begin
                req_read     <= bus.i_agu2lsu_read;
                req_unsigned <= bus.i_agu2lsu_unsigned;
                req_sz       <= {bus.i_agu2lsu_word_access,
                                 bus.i_agu2lsu_short_access,
                                 bus.i_agu2lsu_byte_access};
                req_addr     <= bus.i_agu2lsu_addr;
                req_wdata    <= bus.i_agu2lsu_wdata;
                req_wmask    <= bus.i_agu2lsu_wmask;
                req_info     <= bus.i_agu2lsu_info;
                if (has_excp) begin
                    wb_data <= '0;
                    wb_info <= bus.i_agu2lsu_info;
                end
            end
            if (state == RSP && rsp && !flush) begin
                wb_data <= (bus.i_mem2lsu_err || !req_read) ? '0 : load_data;
                wb_info <= req_info;
                if (bus.i_mem2lsu_err)
                    wb_info[15:0] <= req_info[15:0] | err_excp;
            end
        end
    end
endmodule

// File: tb/tb_hicore_lsu.sv
// Directed bench for hicore_lsu: scoreboard of expected memory commands and
// writeback results, plus literal checks on latency, flush and reset.
module tb_hicore_lsu;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int IRQ_W = 4;
    localparam int ROB_W = 5;
    localparam int IW    = 16 + 32 + IRQ_W + ROB_W;

    typedef struct packed {
        logic          read;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [3:0]    wmask;
    } cmd_t;

    typedef struct packed {
        logic [31:0]   data;
        logic [IW-1:0] info;
    } wb_t;

    typedef struct {
        logic          cancel;
        logic          read;
        logic          uns;
        int            sz;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [3:0]    wmask;
        logic [IW-1:0] info;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;

    hicore_lsu_if #(.ADDR_W(AW), .DATA_W(DW), .INFO_W(IW)) bus();

    hicore_lsu #(.ADDR_W(AW), .DATA_W(DW), .IRQ_W(IRQ_W), .ROB_W(ROB_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int cmd_cnt = 0;
    int wb_cnt = 0;
    int last_wb_cyc = 0;
    logic [31:0] last_data;
    logic [IW-1:0] last_info;
    cmd_t cmd_q[$];
    wb_t wb_q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: event missing or unexpected", nm);
    endtask

    function automatic logic [IW-1:0] mk_info(input int rob, input logic [31:0] pc, input logic [15:0] ex);
        logic [4:0] r5;
        r5 = rob[4:0];
        return {r5, pc, 4'h3, ex};
    endfunction

    // sz: 0 byte, 1 half, 2 word
    function automatic logic [31:0] load_fmt(input logic [31:0] addr, input logic [31:0] rd,
                                             input int sz, input logic uns);
        logic [31:0] v;
        int unsigned off;
        v = rd;
        if (sz == 0) begin
            off = addr % 4;
            v = (rd / (32'd1 << (8 * off))) % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 1) begin
            off = (addr % 4) / 2;
            v = (rd / (32'd1 << (16 * off))) % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic wb_t exp_wb(input req_t r, input logic [31:0] rd, input logic err);
        wb_t w;
        w.data = (!r.read || err) ? 32'h0 : load_fmt(r.addr, rd, r.sz, r.uns);
        w.info = r.info;
        if (err) w.info[15:0] = w.info[15:0] | (r.read ? 16'h0020 : 16'h0080);
        return w;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Single compare process: every handshake is checked against the queues.
    initial begin
        logic pend_m, pend_w;
        cmd_t cur_c, hold_c, ec;
        wb_t cur_w, hold_w, ew;
        pend_m = 1'b0;
        pend_w = 1'b0;
        forever begin
            @(negedge clk);
            cur_c = {bus.o_lsu2mem_read, bus.o_lsu2mem_addr,
                     bus.o_lsu2mem_wdata, bus.o_lsu2mem_wmask};
            cur_w = {bus.o_lsu2wb_data, bus.o_lsu2wb_info};
            if (!rst_n) begin
                pend_m = 1'b0;
                pend_w = 1'b0;
            end else begin
                if (pend_m && bus.o_lsu2mem_valid) chk("cmd_stable", cur_c, hold_c);
                if (pend_w && bus.o_lsu2wb_valid) chk("wb_stable", cur_w, hold_w);
                if (bus.o_lsu2mem_valid && bus.i_lsu2mem_ready) begin
                    cmd_cnt++;
                    if (cmd_q.size() == 0) fail_now("cmd_unexpected");
                    else begin
                        ec = cmd_q.pop_front();
                        chk("cmd", cur_c, ec);
                    end
                end
                if (bus.o_lsu2wb_valid && bus.i_lsu2wb_ready) begin
                    wb_cnt++;
                    last_wb_cyc = cyc;
                    last_data = bus.o_lsu2wb_data;
                    last_info = bus.o_lsu2wb_info;
                    if (wb_q.size() == 0) fail_now("wb_unexpected");
                    else begin
                        ew = wb_q.pop_front();
                        chk("wb", cur_w, ew);
                    end
                end
                pend_m = bus.o_lsu2mem_valid & ~bus.i_lsu2mem_ready;
                pend_w = bus.o_lsu2wb_valid & ~bus.i_lsu2wb_ready;
                hold_c = cur_c;
                hold_w = cur_w;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input req_t r);
        bus.i_agu2lsu_valid        = 1'b1;
        bus.i_agu2lsu_cancel       = r.cancel;
        bus.i_agu2lsu_read         = r.read;
        bus.i_agu2lsu_unsigned     = r.uns;
        bus.i_agu2lsu_byte_access  = (r.sz == 0);
        bus.i_agu2lsu_short_access = (r.sz == 1);
        bus.i_agu2lsu_word_access  = (r.sz == 2);
        bus.i_agu2lsu_addr         = r.addr;
        bus.i_agu2lsu_wdata        = r.wdata;
        bus.i_agu2lsu_wmask        = r.wmask;
        bus.i_agu2lsu_info         = r.info;
    endtask

    task automatic run_op(input req_t r, input logic [31:0] rd, input logic err,
                          input int mem_wait, output int lat);
        int acc_cyc;
        bit ok;
        lat = -1;
        drive_req(r);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_agu2lsu_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            fail_now("timeout_accept");
            bus.i_agu2lsu_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        if (!r.cancel) begin
            if (r.info[15:0] != 16'h0) wb_q.push_back({32'h0, r.info});
            else begin
                cmd_q.push_back({r.read, r.addr & 32'hFFFF_FFFC, r.wdata, r.wmask});
                wb_q.push_back(exp_wb(r, rd, err));
            end
        end
        step();
        bus.i_agu2lsu_valid = 1'b0;
        if (mem_wait > 0) bus.i_lsu2mem_ready = 1'b0;
        if (r.cancel) begin
            repeat (3) step();
            return;
        end
        if (r.info[15:0] == 16'h0) begin
            repeat (mem_wait) step();
            bus.i_lsu2mem_ready = 1'b1;
            ok = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.o_lsu2mem_valid && bus.i_lsu2mem_ready) begin ok = 1; break; end
            end
            if (!ok) begin
                fail_now("timeout_cmd");
                return;
            end
            step();
            bus.i_mem2lsu_valid = 1'b1;
            bus.i_mem2lsu_rdata = rd;
            bus.i_mem2lsu_err   = err;
            step();
            bus.i_mem2lsu_valid = 1'b0;
            bus.i_mem2lsu_err   = 1'b0;
        end
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_lsu2wb_valid && bus.i_lsu2wb_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            fail_now("timeout_wb");
            return;
        end
        lat = cyc - acc_cyc;
        step();
    endtask

    function automatic req_t mk_req(input logic rd, input logic uns, input int sz,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    input logic [3:0] wm, input logic [IW-1:0] inf);
        req_t r;
        r.cancel = 1'b0;
        r.read = rd;
        r.uns = uns;
        r.sz = sz;
        r.addr = a;
        r.wdata = wd;
        r.wmask = wm;
        r.info = inf;
        return r;
    endfunction

    initial begin
        req_t r;
        int lat, c0, w0;

        bus.i_agu2lsu_valid = 1'b0;
        drive_req(mk_req(1'b0, 1'b0, 2, 32'h0, 32'h0, 4'h0, '0));
        bus.i_agu2lsu_valid = 1'b0;
        bus.i_lsu2mem_ready = 1'b1;
        bus.i_mem2lsu_valid = 1'b0;
        bus.i_mem2lsu_rdata = 32'h0;
        bus.i_mem2lsu_err   = 1'b0;
        bus.i_lsu2wb_ready  = 1'b1;

        #2 rst_n = 1'b0;
        #10;
        chk("rst_agu_ready", bus.o_agu2lsu_ready, 1'b1);
        chk("rst_mem_valid", bus.o_lsu2mem_valid, 1'b0);
        chk("rst_wb_valid", bus.o_lsu2wb_valid, 1'b0);
        chk("rst_mem_addr", bus.o_lsu2mem_addr, 32'h0);
        chk("rst_wb_info", {bus.o_lsu2wb_data, bus.o_lsu2wb_info}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        chk("model_sbyte", load_fmt(32'h1003, 32'h80AA_BBCC, 0, 1'b0), 32'hFFFF_FF80);
        chk("model_uhalf", load_fmt(32'h2002, 32'h8001_1234, 1, 1'b1), 32'h0000_8001);
        chk("model_shalf", load_fmt(32'h2002, 32'h8001_1234, 1, 1'b0), 32'hFFFF_8001);

        r = mk_req(1'b1, 1'b0, 0, 32'h1003, 32'h0, 4'h0, mk_info(3, 32'h100, 16'h0));
        run_op(r, 32'h80AA_BBCC, 1'b0, 0, lat);
        chk("sbyte_data", last_data, 32'hFFFF_FF80);
        chk("sbyte_excp", last_info[15:0], 16'h0000);
        chk("load_latency", lat, 3);

        r = mk_req(1'b1, 1'b1, 1, 32'h2002, 32'h0, 4'h0, mk_info(4, 32'h104, 16'h0));
        run_op(r, 32'h8001_1234, 1'b0, 0, lat);
        chk("uhalf_data", last_data, 32'h0000_8001);
        r.uns = 1'b0;
        run_op(r, 32'h8001_1234, 1'b0, 0, lat);
        chk("shalf_data", last_data, 32'hFFFF_8001);

        r = mk_req(1'b1, 1'b0, 0, 32'h1001, 32'h0, 4'h0, mk_info(5, 32'h108, 16'h0));
        run_op(r, 32'h1234_7F56, 1'b0, 1, lat);
        chk("sbyte_pos_data", last_data, 32'h0000_007F);

        c0 = cmd_cnt;
        r = mk_req(1'b0, 1'b0, 2, 32'h3000, 32'hDEAD_BEEF, 4'hF, mk_info(6, 32'h10C, 16'h0));
        run_op(r, 32'h5555_5555, 1'b0, 3, lat);
        chk("store_one_cmd", cmd_cnt - c0, 1);
        chk("store_data", last_data, 32'h0);
        chk("store_excp", last_info[15:0], 16'h0000);

        c0 = cmd_cnt;
        r = mk_req(1'b1, 1'b0, 2, 32'h4001, 32'h0, 4'h0, mk_info(7, 32'h110, 16'h0010));
        run_op(r, 32'h0, 1'b0, 0, lat);
        chk("excp_no_cmd", cmd_cnt - c0, 0);
        chk("excp_latency", lat, 1);
        chk("excp_info", last_info[15:0], 16'h0010);
        chk("excp_data", last_data, 32'h0);

        r = mk_req(1'b1, 1'b0, 2, 32'h5000, 32'h0, 4'h0, mk_info(8, 32'h114, 16'h0));
        run_op(r, 32'hCAFE_F00D, 1'b1, 0, lat);
        chk("ld_err_excp", last_info[15:0], 16'h0020);
        chk("ld_err_data", last_data, 32'h0);
        chk("ld_err_tag", last_info[IW-1:16], r.info[IW-1:16]);
        r = mk_req(1'b0, 1'b0, 1, 32'h5002, 32'h7777_7777, 4'hC, mk_info(9, 32'h118, 16'h0));
        run_op(r, 32'h0, 1'b1, 0, lat);
        chk("st_err_excp", last_info[15:0], 16'h0080);

        c0 = cmd_cnt;
        w0 = wb_cnt;
        r = mk_req(1'b1, 1'b0, 2, 32'h6000, 32'h0, 4'h0, mk_info(10, 32'h11C, 16'h0));
        r.cancel = 1'b1;
        run_op(r, 32'h0, 1'b0, 0, lat);
        chk("cancel_no_cmd", cmd_cnt - c0, 0);
        chk("cancel_no_wb", wb_cnt - w0, 0);
        @(negedge clk);
        chk("cancel_ready", bus.o_agu2lsu_ready, 1'b1);
        step();

        w0 = wb_cnt;
        r = mk_req(1'b1, 1'b0, 2, 32'h7000, 32'h0, 4'h0, mk_info(11, 32'h120, 16'h0));
        drive_req(r);
        cmd_q.push_back({1'b1, 32'h7000, 32'h0, 4'h0});
        step();
        bus.i_agu2lsu_valid = 1'b0;
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("rsp_flush_ready", bus.o_agu2lsu_ready, 1'b0);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("drain_ready0", bus.o_agu2lsu_ready, 1'b0);
        step();
        @(negedge clk);
        chk("drain_ready1", bus.o_agu2lsu_ready, 1'b0);
        step();
        bus.i_mem2lsu_valid = 1'b1;
        bus.i_mem2lsu_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("drain_wb_valid", bus.o_lsu2wb_valid, 1'b0);
        step();
        bus.i_mem2lsu_valid = 1'b0;
        @(negedge clk);
        chk("drain_done_ready", bus.o_agu2lsu_ready, 1'b1);
        chk("drain_no_wb", wb_cnt - w0, 0);
        step();

        r = mk_req(1'b1, 1'b0, 2, 32'h8000, 32'h0, 4'h0, mk_info(12, 32'h124, 16'h0));
        drive_req(r);
        cmd_q.push_back({1'b1, 32'h8000, 32'h0, 4'h0});
        step();
        bus.i_agu2lsu_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("flushcmd_mem_valid", bus.o_lsu2mem_valid, 1'b1);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flushcmd_drain_mem", bus.o_lsu2mem_valid, 1'b0);
        chk("flushcmd_drain_rdy", bus.o_agu2lsu_ready, 1'b0);
        step();
        bus.i_mem2lsu_valid = 1'b1;
        step();
        bus.i_mem2lsu_valid = 1'b0;
        @(negedge clk);
        chk("flushcmd_idle_rdy", bus.o_agu2lsu_ready, 1'b1);
        chk("flushcmd_no_wb", wb_cnt - w0, 0);
        step();

        r = mk_req(1'b1, 1'b0, 1, 32'h2002, 32'h0, 4'h0, mk_info(13, 32'h128, 16'h0));
        run_op(r, 32'h8001_1234, 1'b0, 0, lat);
        chk("post_flush_data", last_data, 32'hFFFF_8001);

        bus.i_lsu2wb_ready = 1'b0;
        r = mk_req(1'b1, 1'b0, 2, 32'h9000, 32'h0, 4'h0, mk_info(14, 32'h12C, 16'h0004));
        drive_req(r);
        step();
        bus.i_agu2lsu_valid = 1'b0;
        @(negedge clk);
        chk("rstwb_valid_before", bus.o_lsu2wb_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstwb_wb_valid", bus.o_lsu2wb_valid, 1'b0);
        chk("rstwb_mem_valid", bus.o_lsu2mem_valid, 1'b0);
        chk("rstwb_info", bus.o_lsu2wb_info, '0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_lsu2wb_ready = 1'b1;
        step();
        @(negedge clk);
        chk("rstwb_ready", bus.o_agu2lsu_ready, 1'b1);
        step();

        chk("cmd_q_empty", cmd_q.size(), 0);
        chk("wb_q_empty", wb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: run did not complete");
        $fatal(1);
    end
endmodule
